// File: rtl/vcu_pkg.sv
// rtl/vcu_pkg.sv - opcode, ALU control, FSM state and control-word types for vector_control_unit
package vcu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_ORR = 4'b0011,
    OP_LSL = 4'b0100,
    OP_CMP = 4'b0101,
    OP_SET = 4'b0110,
    OP_LDR = 4'b0111,
    OP_STR = 4'b1000,
    OP_BEQ = 4'b1010,
    OP_BGE = 4'b1011,
    OP_NOP = 4'b1100
  } opcode_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_ORR  = 4'b0011;
  localparam logic [3:0] ALU_LSL  = 4'b0100;
  localparam logic [3:0] ALU_CMP  = 4'b0101;
  localparam logic [3:0] ALU_SET  = 4'b0110;
  localparam logic [3:0] ALU_LDR  = 4'b0111;
  localparam logic [3:0] ALU_STR  = 4'b1000;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;
  localparam logic [3:0] ALU_BGE  = 4'b1011;
  localparam logic [3:0] ALU_NONE = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       result_src;
    logic [3:0] alu_control;
  } ctl_word_t;

  // Data-path ops run once per beat; CMP/SET/branch/NOP stay single-beat even in vector mode.
  function automatic logic is_vector_op(input logic [3:0] op);
    return (op <= OP_LSL) || (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/vcu_decoder.sv
// rtl/vcu_decoder.sv - combinational opcode/imm to control-word decode; unknown opcodes are END
module vcu_decoder
  import vcu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       imm,
  output ctl_word_t  ctl,
  output logic       is_end
);

  always_comb begin
    ctl    = '0;
    is_end = 1'b0;
    case (opcode)
      OP_ADD:  ctl = '{1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD};
      OP_SUB:  ctl = '{1'b1, 1'b0, 1'b0, 1'b0, ALU_SUB};
      OP_AND:  ctl = '{1'b1, 1'b0, 1'b0, 1'b0, ALU_AND};
      OP_ORR:  ctl = '{1'b1, 1'b0, 1'b0, 1'b0, ALU_ORR};
      OP_LSL:  ctl = '{1'b1, 1'b0, 1'b0, 1'b0, ALU_LSL};
      OP_CMP:  ctl = '{1'b0, 1'b0, 1'b0, 1'b0, ALU_CMP};
      OP_SET:  ctl = '{1'b1, 1'b0, 1'b0, imm,  ALU_SET};
      OP_LDR:  ctl = '{1'b1, 1'b0, 1'b0, 1'b1, ALU_LDR};
      OP_STR:  ctl = '{1'b0, 1'b1, 1'b0, 1'b1, ALU_STR};
      OP_BEQ:  ctl = '{1'b0, 1'b0, 1'b1, 1'b1, ALU_BEQ};
      OP_BGE:  ctl = '{1'b0, 1'b0, 1'b1, 1'b1, ALU_BGE};
      OP_NOP:  ctl = '{1'b0, 1'b0, 1'b0, 1'b0, ALU_NONE};
      default: is_end = 1'b1;
    endcase
  end

endmodule

// File: rtl/vector_control_unit.sv
// rtl/vector_control_unit.sv - sequential control unit: handshake, beat sequencing, branch resolution
// Optional VCU_PERF_CNT_EN adds saturating perf_instr_cnt / perf_beat_cnt outputs.
module vector_control_unit
  import vcu_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int VEC_LEN   = 16,
  parameter int NUM_BEATS = VEC_LEN / LANES,
  parameter int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic              imm,
  input  logic              vec,
  input  logic              flag_z,
  input  logic              flag_n,
  input  logic              ctl_stall,
  output logic              ctl_valid,
  output logic              reg_write,
  output logic              mem_write,
  output logic              branch,
  output logic              branch_taken,
  output logic              result_src,
  output logic [3:0]        alu_control,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              last_beat,
  output logic              halted
`ifdef VCU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_instr_cnt,
  output logic [31:0]       perf_beat_cnt
`endif
);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NUM_BEATS - 1);

  state_e            state_q, state_d;
  ctl_word_t         ctl_q, ctl_d, dec_ctl;
  logic              ctl_valid_q, ctl_valid_d;
  logic              taken_q, taken_d;
  logic [BEAT_W-1:0] beat_q, beat_d, beat_inc;
  logic              last_q, last_d;
  logic              halted_q, halted_d;
  logic              started_q, started_d;
  logic              dec_end, accept, load, multi, taken_now;

  vcu_decoder u_decoder (
    .opcode (opcode),
    .imm    (imm),
    .ctl    (dec_ctl),
    .is_end (dec_end)
  );

  // started_q keeps instr_ready low during reset and raises it one cycle after release.
  assign instr_ready = started_q &&
                       ((state_q == ST_IDLE) || (state_q == ST_EXEC && last_q && !ctl_stall));
  assign accept      = instr_valid && instr_ready;
  assign multi       = vec && is_vector_op(opcode) && (NUM_BEATS > 1);
  assign taken_now   = ((opcode == OP_BEQ) && flag_z) || ((opcode == OP_BGE) && !flag_n);
  assign beat_inc    = beat_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ctl_d       = ctl_q;
    ctl_valid_d = ctl_valid_q;
    taken_d     = taken_q;
    beat_d      = beat_q;
    last_d      = last_q;
    halted_d    = halted_q;
    started_d   = 1'b1;
    load        = 1'b0;
    case (state_q)
      ST_IDLE: load = accept;
      ST_EXEC: begin
        if (!ctl_stall) begin
          if (!last_q) begin
            beat_d = beat_inc;
            last_d = (beat_inc == BEAT_LAST);
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            ctl_d       = '0;
            ctl_valid_d = 1'b0;
            taken_d     = 1'b0;
            beat_d      = '0;
            last_d      = 1'b0;
          end
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      beat_d = '0;
      if (dec_end) begin
        state_d     = ST_HALT;
        halted_d    = 1'b1;
        ctl_d       = '0;
        ctl_valid_d = 1'b0;
        taken_d     = 1'b0;
        last_d      = 1'b0;
      end else begin
        state_d     = ST_EXEC;
        ctl_d       = dec_ctl;
        ctl_valid_d = 1'b1;
        taken_d     = taken_now;
        last_d      = !multi;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ctl_q       <= '0;
      ctl_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      beat_q      <= '0;
      last_q      <= 1'b0;
      halted_q    <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctl_q       <= ctl_d;
      ctl_valid_q <= ctl_valid_d;
      taken_q     <= taken_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      halted_q    <= halted_d;
      started_q   <= started_d;
    end
  end

  assign ctl_valid    = ctl_valid_q;
  assign reg_write    = ctl_q.reg_write;
  assign mem_write    = ctl_q.mem_write;
  assign branch       = ctl_q.branch;
  assign result_src   = ctl_q.result_src;
  assign alu_control  = ctl_q.alu_control;
  assign branch_taken = taken_q;
  assign beat_idx     = beat_q;
  assign last_beat    = last_q;
  assign halted       = halted_q;

`ifdef VCU_PERF_CNT_EN
  logic [31:0] instr_cnt_q, instr_cnt_d, beat_cnt_q, beat_cnt_d;

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    if (accept && (instr_cnt_q != '1)) instr_cnt_d = instr_cnt_q + 32'd1;
    if (ctl_valid_q && !ctl_stall && (beat_cnt_q != '1)) beat_cnt_d = beat_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign perf_instr_cnt = instr_cnt_q;
  assign perf_beat_cnt  = beat_cnt_q;
`endif

endmodule
